battleship_phase_ctrl: RTL and testbench

//  Game-phase controller for two-player Battleship: owns both players' ship maps and shot maps, sequences placement -> alternating attacks -> win.

---
 rtl/battleship_phase_ctrl.sv | 152 +++++++++++++++
 tb/tb_battleship_phase_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/battleship_phase_ctrl.sv
// Two-player Battleship phase controller: ship placement, alternating attacks, win detection.
// Every output is a flop, so each confirm or restart shows its effect one cycle later.
module battleship_phase_ctrl #(
    parameter int GRID_W    = 4,
    parameter int NUM_SHIPS = 4,
    parameter int CW        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn_confirm,
    input  logic                           btn_restart,
    input  logic [CW-1:0]                  cursor,
    output logic [2:0]                     status_digit,
    output logic                           hit_pulse,
    output logic                           miss_pulse,
    output logic                           reject_pulse,
    output logic [$clog2(NUM_SHIPS+1)-1:0] hits_p1,
    output logic [$clog2(NUM_SHIPS+1)-1:0] hits_p2,
    output logic                           game_over
);

    localparam int NUM_CELLS = GRID_W * GRID_W;
    localparam int HW        = $clog2(NUM_SHIPS + 1);
    localparam logic [HW-1:0] SHIPS_C = HW'(NUM_SHIPS);

    typedef enum logic [2:0] {
        PLACE_P1 = 3'b000,
        PLACE_P2 = 3'b001,
        ATK_P1   = 3'b010,
        ATK_P2   = 3'b011,
        WIN_P1   = 3'b100,
        WIN_P2   = 3'b101
    } state_t;

    state_t               r_state;
    logic [NUM_CELLS-1:0] r_ships_p1, r_ships_p2;
    logic [NUM_CELLS-1:0] r_shots_p1, r_shots_p2;
    logic [HW-1:0]        r_placed;
    logic [HW-1:0]        r_hits_p1, r_hits_p2;
    logic                 r_hit, r_miss, r_reject, r_game_over;

    logic                 w_legal;
    logic                 w_clear;
    logic                 w_sel_ship;
    logic                 w_sel_shot;
    logic                 w_opp_ship;
    logic [HW-1:0]        w_placed_inc;
    logic [HW-1:0]        w_att_hits_inc;
    state_t               w_pass;

    // A cursor can only exceed the board when its encoding has spare codes.
    if (2**CW > NUM_CELLS) begin : g_range
        assign w_legal = (cursor < CW'(NUM_CELLS));
    end else begin : g_full
        assign w_legal = 1'b1;
    end

    assign w_clear        = !rst_n || (btn_restart && (r_state == WIN_P1 || r_state == WIN_P2));
    assign w_placed_inc   = r_placed + 1'b1;
    assign w_att_hits_inc = ((r_state == ATK_P1) ? r_hits_p1 : r_hits_p2) + 1'b1;
    assign w_pass         = (r_state == ATK_P1) ? ATK_P2 : ATK_P1;

    // NOTE: every signal driven here is given a default first, so no latch is inferred.
    always_comb begin
        w_sel_ship = 1'b0;
        w_sel_shot = 1'b0;
        w_opp_ship = 1'b0;
        if (w_legal) begin
            case (r_state)
                PLACE_P1: w_sel_ship = r_ships_p1[cursor];
                PLACE_P2: w_sel_ship = r_ships_p2[cursor];
                ATK_P1: begin
                    w_sel_shot = r_shots_p1[cursor];
                    w_opp_ship = r_ships_p2[cursor];
                end
                ATK_P2: begin
                    w_sel_shot = r_shots_p2[cursor];
                    w_opp_ship = r_ships_p1[cursor];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere; pulses default low so each lasts exactly one clock.
        r_hit    <= 1'b0;
        r_miss   <= 1'b0;
        r_reject <= 1'b0;
        if (w_clear) begin
            // NOTE: the maps are plain flops, not RAM, so the whole board clears on a single edge.
            r_state     <= PLACE_P1;
            r_ships_p1  <= '0;
            r_ships_p2  <= '0;
            r_shots_p1  <= '0;
            r_shots_p2  <= '0;
            r_placed    <= '0;
            r_hits_p1   <= '0;
            r_hits_p2   <= '0;
            r_game_over <= 1'b0;
        end else if (btn_confirm) begin
            case (r_state)
                PLACE_P1, PLACE_P2: begin
                    if (!w_legal || w_sel_ship) begin
                        r_reject <= 1'b1;
                    end else begin
                        if (r_state == PLACE_P1) r_ships_p1[cursor] <= 1'b1;
                        else                     r_ships_p2[cursor] <= 1'b1;
                        if (w_placed_inc == SHIPS_C) begin
                            r_placed <= '0;
                            r_state  <= (r_state == PLACE_P1) ? PLACE_P2 : ATK_P1;
                        end else begin
                            r_placed <= w_placed_inc;
                        end
                    end
                end
                ATK_P1, ATK_P2: begin
                    if (!w_legal || w_sel_shot) begin
                        r_reject <= 1'b1;
                    end else begin
                        if (r_state == ATK_P1) r_shots_p1[cursor] <= 1'b1;
                        else                   r_shots_p2[cursor] <= 1'b1;
                        if (w_opp_ship) begin
                            r_hit <= 1'b1;
                            if (r_state == ATK_P1) r_hits_p1 <= w_att_hits_inc;
                            else                   r_hits_p2 <= w_att_hits_inc;
                            if (w_att_hits_inc == SHIPS_C) begin
                                r_state     <= (r_state == ATK_P1) ? WIN_P1 : WIN_P2;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= w_pass;
                            end
                        end else begin
                            r_miss  <= 1'b1;
                            r_state <= w_pass;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign status_digit = r_state;
    assign hit_pulse    = r_hit;
    assign miss_pulse   = r_miss;
    assign reject_pulse = r_reject;
    assign hits_p1      = r_hits_p1;
    assign hits_p2      = r_hits_p2;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_battleship_phase_ctrl.sv
// Scoreboard bench for battleship_phase_ctrl: the driver queues a hand-computed expectation
// for every cycle it drives, and a monitor compares it against the outputs half a clock later.
module tb_battleship_phase_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       hit;
        logic       miss;
        logic       rej;
        logic [2:0] h1;
        logic [2:0] h2;
        logic       go;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_confirm = 1'b0;
    logic          btn_restart = 1'b0;
    logic [CW-1:0] cursor = '0;
    logic [2:0]    status_digit;
    logic          hit_pulse, miss_pulse, reject_pulse, game_over;
    logic [2:0]    hits_p1, hits_p2;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur_exp;
    string cur_name;
    bit    have = 1'b0;
    int    checks = 0;
    int    errors = 0;

    battleship_phase_ctrl #(.GRID_W(4), .NUM_SHIPS(4), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_confirm  (btn_confirm),
        .btn_restart  (btn_restart),
        .cursor       (cursor),
        .status_digit (status_digit),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .reject_pulse (reject_pulse),
        .hits_p1      (hits_p1),
        .hits_p2      (hits_p2),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%b hit=%b miss=%b rej=%b h1=%0d h2=%0d go=%b, expected st=%b hit=%b miss=%b rej=%b h1=%0d h2=%0d go=%b",
                     nm, act.st, act.hit, act.miss, act.rej, act.h1, act.h2, act.go,
                     exp.st, exp.hit, exp.miss, exp.rej, exp.h1, exp.h2, exp.go);
        end
    endtask

    // Monitor: claim the expectation for the edge being sampled, compare after it settles.
    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            cur_name = name_q.pop_front();
            have     = 1'b1;
        end else begin
            have = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (have) begin
            check(cur_name,
                  '{st: status_digit, hit: hit_pulse, miss: miss_pulse, rej: reject_pulse,
                    h1: hits_p1, h2: hits_p2, go: game_over},
                  cur_exp);
            have = 1'b0;
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic drv(input logic c, input logic r, input logic n, input logic [CW-1:0] cur,
                       input logic [2:0] st, input logic hit, input logic miss, input logic rej,
                       input logic [2:0] h1, input logic [2:0] h2, input logic go,
                       input string nm);
        @(negedge clk);
        btn_confirm = c;
        btn_restart = r;
        rst_n       = n;
        cursor      = cur;
        exp_q.push_back('{st: st, hit: hit, miss: miss, rej: rej, h1: h1, h2: h2, go: go});
        name_q.push_back(nm);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        //  c  r  n  cur  st     hit miss rej h1 h2 go
        drv(0, 0, 0, 0,  3'b000, 0, 0, 0, 0, 0, 0, "reset");
        drv(1, 0, 1, 5,  3'b000, 0, 0, 0, 0, 0, 0, "place5");
        drv(1, 0, 1, 5,  3'b000, 0, 0, 1, 0, 0, 0, "place5_dup_reject");
        drv(0, 0, 1, 0,  3'b000, 0, 0, 0, 0, 0, 0, "reject_one_cycle");
        drv(0, 0, 0, 0,  3'b000, 0, 0, 0, 0, 0, 0, "reset2");
        drv(1, 0, 1, 0,  3'b000, 0, 0, 0, 0, 0, 0, "p1_place0");
        drv(1, 0, 1, 1,  3'b000, 0, 0, 0, 0, 0, 0, "p1_place1");
        drv(1, 0, 1, 2,  3'b000, 0, 0, 0, 0, 0, 0, "p1_place2");
        drv(1, 0, 1, 3,  3'b001, 0, 0, 0, 0, 0, 0, "p1_place3_adv");
        drv(0, 1, 1, 0,  3'b001, 0, 0, 0, 0, 0, 0, "restart_ignored_place");
        drv(1, 0, 1, 8,  3'b001, 0, 0, 0, 0, 0, 0, "p2_place8");
        drv(1, 0, 1, 9,  3'b001, 0, 0, 0, 0, 0, 0, "p2_place9");
        drv(1, 0, 1, 10, 3'b001, 0, 0, 0, 0, 0, 0, "p2_place10");
        drv(1, 0, 1, 11, 3'b010, 0, 0, 0, 0, 0, 0, "p2_place11_adv");
        drv(1, 0, 1, 8,  3'b011, 1, 0, 0, 1, 0, 0, "p1_hit8");
        drv(1, 0, 1, 15, 3'b010, 0, 1, 0, 1, 0, 0, "p2_miss15");
        drv(0, 0, 1, 0,  3'b010, 0, 0, 0, 1, 0, 0, "idle_atk");
        drv(1, 0, 1, 8,  3'b010, 0, 0, 1, 1, 0, 0, "p1_refire8_reject");
        drv(1, 0, 1, 9,  3'b011, 1, 0, 0, 2, 0, 0, "p1_hit9");
        drv(1, 0, 1, 0,  3'b010, 1, 0, 0, 2, 1, 0, "p2_hit0");
        drv(1, 0, 1, 4,  3'b011, 0, 1, 0, 2, 1, 0, "p1_miss4");
        drv(1, 0, 1, 1,  3'b010, 1, 0, 0, 2, 2, 0, "p2_hit1");
        drv(1, 0, 1, 10, 3'b011, 1, 0, 0, 3, 2, 0, "p1_hit10");
        drv(1, 1, 1, 14, 3'b010, 0, 1, 0, 3, 2, 0, "p2_miss14_restart_ignored");
        drv(1, 0, 1, 11, 3'b100, 1, 0, 0, 4, 2, 1, "p1_win");
        drv(1, 0, 1, 12, 3'b100, 0, 0, 0, 4, 2, 1, "win_confirm_ignored");
        drv(1, 1, 1, 13, 3'b000, 0, 0, 0, 0, 0, 0, "win_restart_beats_confirm");
        drv(1, 0, 1, 0,  3'b000, 0, 0, 0, 0, 0, 0, "replace0_map_cleared");
        drv(1, 0, 1, 1,  3'b000, 0, 0, 0, 0, 0, 0, "replace1");
        drv(1, 0, 1, 2,  3'b000, 0, 0, 0, 0, 0, 0, "replace2");
        drv(1, 0, 1, 3,  3'b001, 0, 0, 0, 0, 0, 0, "replace3_adv");
        drv(1, 0, 1, 8,  3'b001, 0, 0, 0, 0, 0, 0, "p2_replace8");
        drv(1, 0, 1, 9,  3'b001, 0, 0, 0, 0, 0, 0, "p2_replace9");
        drv(1, 0, 1, 10, 3'b001, 0, 0, 0, 0, 0, 0, "p2_replace10");
        drv(1, 0, 1, 11, 3'b010, 0, 0, 0, 0, 0, 0, "p2_replace11_adv");
        drv(1, 0, 1, 8,  3'b011, 1, 0, 0, 1, 0, 0, "p1_hit8_shots_cleared");
        drv(1, 0, 1, 0,  3'b010, 1, 0, 0, 1, 1, 0, "p2_hit0_g2");
        drv(1, 0, 1, 4,  3'b011, 0, 1, 0, 1, 1, 0, "p1_miss4_g2");
        drv(1, 0, 1, 1,  3'b010, 1, 0, 0, 1, 2, 0, "p2_hit1_g2");
        drv(1, 0, 1, 5,  3'b011, 0, 1, 0, 1, 2, 0, "p1_miss5_g2");
        drv(1, 0, 0, 2,  3'b000, 0, 0, 0, 0, 0, 0, "midgame_reset");
        drv(0, 0, 1, 0,  3'b000, 0, 0, 0, 0, 0, 0, "after_reset_idle");

        for (int i = 0; i < 5 && (exp_q.size() > 0 || have); i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
